// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first full-adder slice from two half_adders.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module half_adder (
  input  logic in1,
  input  logic in2,
  output logic sum,
  output logic count
);
  assign sum   = in1 ^ in2;
  assign count = in1 & in2;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] sum,
  output logic             count,
  output logic             done
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_next;
  logic             carry_q;
  logic [5:0]       bitcnt_q;
  logic             last;
  logic             p;
  logic             g0;
  logic             s;
  logic             g1;
  logic             c_out;

  half_adder u_ha0 (
    .in1   (a_q[0]),
    .in2   (b_q[0]),
    .sum   (p),
    .count (g0)
  );

  half_adder u_ha1 (
    .in1   (p),
    .in2   (carry_q),
    .sum   (s),
    .count (g1)
  );

  assign c_out = g0 | g1;
  assign last  = (bitcnt_q == LAST);
  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

  // New sum bit enters at the MSB; result shifts toward the LSB
  always_comb begin
    res_next = res_q >> 1;
    res_next[WIDTH-1] = s;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand shifters, carry FF, bit counter and held result
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      bitcnt_q <= '0;
      sum      <= '0;
      count    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf      <= 1'b0;
`endif
    end else if (state_q == IDLE && start) begin
      a_q      <= in1;
      b_q      <= in2;
      carry_q  <= cin;
      bitcnt_q <= '0;
    end else if (state_q == RUN) begin
      a_q      <= a_q >> 1;
      b_q      <= b_q >> 1;
      res_q    <= res_next;
      carry_q  <= c_out;
      bitcnt_q <= bitcnt_q + 6'd1;
      if (last) begin
        sum   <= res_next;
        count <= c_out;
`ifdef SERIAL_ADDER_OVF_EN
        ovf   <= carry_q ^ c_out;
`endif
      end
    end
  end

endmodule
